// File: rtl/jtframe_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sram_arbiter
// Description : Two-port (line writer A / line reader B) arbiter and timing
//               controller for an asynchronous 16-bit SRAM.
//               Optional macro JTFRAME_SRAM_ARB_PRIO_EN: port B wins all ties.
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_sram_arbiter #(
    parameter int AW   = 21,
    parameter int WAIT = 2
)(
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_din,
    input  logic [1:0]    a_dsn,
    output logic          a_ack,
    output logic [15:0]   a_dout,
    output logic          a_dok,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [15:0]   b_din,
    input  logic [1:0]    b_dsn,
    output logic          b_ack,
    output logic [15:0]   b_dout,
    output logic          b_dok,

    output logic [AW-1:0] sram_addr,
    inout  wire  [15:0]   sram_data,
    output logic          sram_we,
    output logic          sram_oe,
    output logic          sram_ub,
    output logic          sram_lb
);

    localparam int c_wait = (WAIT < 1) ? 1 : WAIT;
    localparam int c_cw   = (c_wait > 1) ? $clog2(c_wait) : 1;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(c_wait - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_sel_b;
    logic            r_last_b;
    logic            r_we;
    logic [15:0]     r_din;
    logic            r_drive;

    logic            w_any;
    logic            w_pick_b;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [15:0]     w_din;
    logic [1:0]      w_dsn;

    assign w_any = a_req | b_req;
`ifdef JTFRAME_SRAM_ARB_PRIO_EN
    assign w_pick_b = b_req;
`else
    // On a tie, the port that was not served last wins
    assign w_pick_b = b_req & (~a_req | ~r_last_b);
`endif

    assign w_we   = w_pick_b ? b_we   : a_we;
    assign w_addr = w_pick_b ? b_addr : a_addr;
    assign w_din  = w_pick_b ? b_din  : a_din;
    assign w_dsn  = w_pick_b ? b_dsn  : a_dsn;

    assign sram_data = r_drive ? r_din : 16'hzzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sel_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_we      <= 1'b0;
            r_din     <= '0;
            r_drive   <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_dok     <= 1'b0;
            b_dok     <= 1'b0;
            a_dout    <= '0;
            b_dout    <= '0;
            sram_addr <= '0;
            sram_we   <= 1'b1;
            sram_oe   <= 1'b1;
            sram_ub   <= 1'b1;
            sram_lb   <= 1'b1;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_dok <= 1'b0;
            b_dok <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_any) begin
                        r_state   <= ST_SETUP;
                        r_sel_b   <= w_pick_b;
                        r_last_b  <= w_pick_b;
                        r_we      <= w_we;
                        r_din     <= w_din;
                        r_drive   <= w_we;
                        a_ack     <= ~w_pick_b;
                        b_ack     <= w_pick_b;
                        sram_addr <= w_addr;
                        sram_we   <= 1'b1;
                        sram_oe   <= 1'b1;
                        // reads always enable both lanes
                        sram_ub   <= w_we ? w_dsn[1] : 1'b0;
                        sram_lb   <= w_we ? w_dsn[0] : 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_drive <= 1'b0;
                        sram_we <= 1'b1;
                        sram_oe <= 1'b1;
                        sram_ub <= 1'b1;
                        sram_lb <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= c_cnt_init;
                    sram_we <= ~r_we;
                    sram_oe <= r_we;
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_HOLD;
                        sram_we <= 1'b1;
                        sram_oe <= 1'b1;
                        if (r_sel_b) b_dok <= 1'b1;
                        else         a_dok <= 1'b1;
                        if (!r_we) begin
                            if (r_sel_b) b_dout <= sram_data;
                            else         a_dout <= sram_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/jtframe_sram_arbiter.md
JTFRAME_SRAM_ARBITER -- requirements
Module: jtframe_sram_arbiter

Interface
REQ-001 Parameter AW, default 21, SRAM word-address width.
REQ-002 Parameter WAIT, default 2, strobe cycles per access; values below 1 SHALL be treated as 1.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 a_req/b_req  in  1 each  access request, level; port A is the line writer, port B is the line reader.
REQ-006 a_we/b_we  in  1 each  1=write, 0=read; sampled at grant.
REQ-007 a_addr/b_addr  in  AW each  word address; sampled at grant.
REQ-008 a_din/b_din  in  16 each  write data; sampled at grant.
REQ-009 a_dsn/b_dsn  in  2 each  active-low byte enables {upper,lower}; sampled at grant.
REQ-010 a_ack/b_ack  out  1 each  one-cycle grant pulse.
REQ-011 a_dout/b_dout  out  16 each  read data, held until that port's next read completes.
REQ-012 a_dok/b_dok  out  1 each  one-cycle completion pulse, read or write.
REQ-013 sram_addr  out  AW  SRAM address; holds last value when idle.
REQ-014 sram_data  inout  16  SRAM data; driven only during a write access, otherwise Z.
REQ-015 sram_we  out  1  active-low write strobe.
REQ-016 sram_oe  out  1  active-low output enable.
REQ-017 sram_ub/sram_lb  out  1 each  active-low byte lanes.

Function
REQ-018 The controller SHALL be an FSM with states IDLE, SETUP, STROBE and HOLD.
REQ-019 Arbitration SHALL occur in IDLE and HOLD; a grant latches the winner's we/addr/din/dsn, pulses its ack in the next cycle, and enters SETUP.
REQ-020 Tie-break SHALL be round-robin: when both requests are high, the port not granted last wins; a single requester always wins.
REQ-021 SETUP SHALL last 1 cycle: sram_addr valid, sram_we=1, sram_oe=1, byte lanes asserted, sram_data driven if write.
REQ-022 STROBE SHALL last WAIT cycles: write drives sram_we=0; read drives sram_oe=0.
REQ-023 A read SHALL capture sram_data into the granted port's dout at the edge ending the last STROBE cycle.
REQ-024 HOLD SHALL last 1 cycle with sram_we=1 and sram_oe=1; write data stays driven through HOLD and is released on exit; the granted port's dok pulses in HOLD.
REQ-025 From HOLD, a pending request SHALL go directly to SETUP; otherwise the FSM returns to IDLE.
REQ-026 Latency SHALL be: request sampled at edge n, ack high in cycle n+1, dok high in cycle n+2+WAIT; back-to-back period is WAIT+2 cycles.
REQ-027 Writes SHALL drive sram_ub/sram_lb from dsn[1]/dsn[0]; reads SHALL drive both lanes 0; when idle both SHALL be 1.
REQ-028 A write with dsn=2'b11 SHALL still run the full sequence with sram_we pulsed and no lane enabled, and SHALL pulse dok.
REQ-029 Requests held high after ack SHALL be treated as new accesses; the requester deasserts req in the ack cycle for a single access.
REQ-030 Input changes after grant SHALL NOT affect the access in progress.

Reset
REQ-031 Reset SHALL immediately force state IDLE, sram_we=sram_oe=sram_ub=sram_lb=1, sram_data=Z, sram_addr=0, acks/doks=0, douts=0, last-granted=B; an aborted access is lost and is neither acked again nor completed.

Configuration
REQ-032 With JTFRAME_SRAM_ARB_PRIO_EN defined, port B SHALL win every tie (fixed priority for the reader); without it, the round-robin of REQ-020 SHALL apply.

Verification (WAIT=2)
REQ-033 A reads 0x00100 with SRAM model at 0xBEEF: req at edge 0 -> a_ack cycle 1, sram_oe low cycles 2-3, a_dok cycle 4, a_dout=0xBEEF.
REQ-034 B writes 0x1234 to 0x1FFFFF with dsn=2'b01 -> sram_we low 2 cycles, sram_ub=0, sram_lb=1, only the upper byte is changed in the model.
REQ-035 A and B held high together from reset -> grants alternate A,B,A,B with period 4 cycles (with PRIO_EN: B only).
REQ-036 Assert rst during the STROBE of a write -> sram_we=1 and sram_data=Z the same cycle, no dok, FSM IDLE after release.
REQ-037 Override WAIT=0 -> behaviour identical to WAIT=1, with dok 3 cycles after the request edge.
